// File: rtl/alu_arbiter_if.sv
// Bus bundle between two operand requesters, the shared ALU and the result consumer.
// The slave modport is the arbiter's view; master is the surrounding logic's view.
interface alu_arbiter_if #(
  parameter int unsigned OPW = 3,
  parameter int unsigned DW  = 3,
  parameter int unsigned FW  = 6
);
  logic           r0_valid;
  logic           r0_ready;
  logic [OPW-1:0] r0_op;
  logic [DW-1:0]  r0_a;
  logic [DW-1:0]  r0_b;

  logic           r1_valid;
  logic           r1_ready;
  logic [OPW-1:0] r1_op;
  logic [DW-1:0]  r1_a;
  logic [DW-1:0]  r1_b;

  logic [OPW-1:0] alu_op;
  logic [DW-1:0]  alu_a;
  logic [DW-1:0]  alu_b;
  logic [FW-1:0]  alu_f;

  logic           rsp_valid;
  logic           rsp_ready;
  logic [FW-1:0]  rsp_data;
  logic           rsp_id;

  logic           busy;

  modport slave (
    input  r0_valid, r0_op, r0_a, r0_b,
    input  r1_valid, r1_op, r1_a, r1_b,
    input  alu_f, rsp_ready,
    output r0_ready, r1_ready,
    output alu_op, alu_a, alu_b,
    output rsp_valid, rsp_data, rsp_id, busy
  );

  modport master (
    output r0_valid, r0_op, r0_a, r0_b,
    output r1_valid, r1_op, r1_a, r1_b,
    output alu_f, rsp_ready,
    input  r0_ready, r1_ready,
    input  alu_op, alu_a, alu_b,
    input  rsp_valid, rsp_data, rsp_id, busy
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters; operands are
// registered, held for SETTLE cycles, and the captured result is returned with its requester id.
module alu_arbiter #(
  parameter int unsigned OPW    = 3,
  parameter int unsigned DW     = 3,
  parameter int unsigned FW     = 6,
  parameter int unsigned SETTLE = 1
) (
  input logic        clk,
  input logic        rst,
  alu_arbiter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  localparam int unsigned CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] CntInit = CW'(SETTLE - 1);

  state_e         state_q;
  logic           last_grant_q;
  logic [CW-1:0]  cnt_q;
  logic [OPW-1:0] alu_op_q;
  logic [DW-1:0]  alu_a_q;
  logic [DW-1:0]  alu_b_q;
  logic           rsp_valid_q;
  logic [FW-1:0]  rsp_data_q;
  logic           rsp_id_q;

  logic gnt0, gnt1;

  // On a tie the requester that did not win last time is granted.
  always_comb begin
    gnt0 = bus.r0_valid && (!bus.r1_valid || last_grant_q);
    gnt1 = bus.r1_valid && (!bus.r0_valid || !last_grant_q);
  end

  assign bus.r0_ready  = (state_q == StIdle) && gnt0;
  assign bus.r1_ready  = (state_q == StIdle) && gnt1;
  assign bus.busy      = (state_q != StIdle);
  assign bus.alu_op    = alu_op_q;
  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_id    = rsp_id_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
      alu_op_q     <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_id_q     <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (gnt0 || gnt1) begin
            alu_op_q     <= gnt1 ? bus.r1_op : bus.r0_op;
            alu_a_q      <= gnt1 ? bus.r1_a  : bus.r0_a;
            alu_b_q      <= gnt1 ? bus.r1_b  : bus.r0_b;
            rsp_id_q     <= gnt1;
            last_grant_q <= gnt1;
            cnt_q        <= CntInit;
            state_q      <= StExec;
          end
        end
        StExec: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
          end else begin
            rsp_data_q  <= bus.alu_f;
            rsp_valid_q <= 1'b1;
            state_q     <= StResp;
          end
        end
        StResp: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: one instance with SETTLE=1, one with SETTLE=3, each
// driving a bench-side ALU model.
module tb_alu_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   viol   = 0;

  always #5 clk = ~clk;

  alu_arbiter_if #(.OPW(3), .DW(3), .FW(6)) b1 ();
  alu_arbiter_if #(.OPW(3), .DW(3), .FW(6)) b3 ();

  alu_arbiter #(.OPW(3), .DW(3), .FW(6), .SETTLE(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (b1)
  );

  alu_arbiter #(.OPW(3), .DW(3), .FW(6), .SETTLE(3)) dut3 (
    .clk (clk),
    .rst (rst),
    .bus (b3)
  );

  function automatic logic [5:0] alu_model(input logic [2:0] op, input logic [2:0] a,
                                           input logic [2:0] b);
    logic [5:0] ea, eb;
    ea = {3'b000, a};
    eb = {3'b000, b};
    case (op)
      3'd0:    return ea & eb;
      3'd1:    return ea + eb;
      3'd2:    return ea - eb;
      3'd3:    return ea * eb;
      3'd4:    return ea >> eb;
      3'd5:    return ea << eb;
      3'd6:    return {3'b000, ~(a ^ b)};
      default: return {5'b00000, (a == b)};
    endcase
  endfunction

  always_comb b1.alu_f = alu_model(b1.alu_op, b1.alu_a, b1.alu_b);
  always_comb b3.alu_f = alu_model(b3.alu_op, b3.alu_a, b3.alu_b);

  // No requester may see ready while its arbiter is busy.
  always @(negedge clk) begin
    if (b1.busy && (b1.r0_ready || b1.r1_ready)) viol++;
    if (b3.busy && (b3.r0_ready || b3.r1_ready)) viol++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_rsp1(input int budget);
    int n = 0;
    while (b1.rsp_valid !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    chk("rsp_timeout", {31'b0, b1.rsp_valid === 1'b1}, 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    b1.r0_valid = 0; b1.r0_op = 0; b1.r0_a = 0; b1.r0_b = 0;
    b1.r1_valid = 0; b1.r1_op = 0; b1.r1_a = 0; b1.r1_b = 0;
    b1.rsp_ready = 0;
    b3.r0_valid = 0; b3.r0_op = 0; b3.r0_a = 0; b3.r0_b = 0;
    b3.r1_valid = 0; b3.r1_op = 0; b3.r1_a = 0; b3.r1_b = 0;
    b3.rsp_ready = 0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk("rst_busy", b1.busy, 0);
    chk("rst_rsp_valid", b1.rsp_valid, 0);
    chk("rst_rsp_data", b1.rsp_data, 0);
    chk("rst_rsp_id", b1.rsp_id, 0);
    chk("rst_alu_op", b1.alu_op, 0);
    chk("rst_alu_a", b1.alu_a, 0);
    chk("rst_r0_ready", b1.r0_ready, 0);

    // Single r0 add
    b1.r0_valid = 1; b1.r0_op = 3'd1; b1.r0_a = 3'd1; b1.r0_b = 3'd2;
    b1.rsp_ready = 1;
    #1;
    chk("t1_r0_ready", b1.r0_ready, 1);
    chk("t1_r1_ready", b1.r1_ready, 0);
    tick();
    b1.r0_valid = 0;
    #1;
    chk("t1_ready_pulse", b1.r0_ready, 0);
    chk("t1_busy", b1.busy, 1);
    chk("t1_alu_op", b1.alu_op, 1);
    chk("t1_alu_a", b1.alu_a, 1);
    chk("t1_alu_b", b1.alu_b, 2);
    chk("t1_no_early_rsp", b1.rsp_valid, 0);
    tick();
    chk("t1_rsp_valid", b1.rsp_valid, 1);
    chk("t1_rsp_data", b1.rsp_data, 3);
    chk("t1_rsp_id", b1.rsp_id, 0);
    tick();
    chk("t1_idle", b1.busy, 0);
    chk("t1_rsp_drop", b1.rsp_valid, 0);
    chk("t1_alu_hold", b1.alu_op, 1);

    // Tie from reset: r0 first, then r1
    do_reset();
    b1.r0_valid = 1; b1.r0_op = 3'd3; b1.r0_a = 3'd3; b1.r0_b = 3'd6;
    b1.r1_valid = 1; b1.r1_op = 3'd2; b1.r1_a = 3'd7; b1.r1_b = 3'd1;
    #1;
    chk("t2_tie_r0", b1.r0_ready, 1);
    chk("t2_tie_r1", b1.r1_ready, 0);
    wait_rsp1(10);
    chk("t2_first_id", b1.rsp_id, 0);
    chk("t2_first_data", b1.rsp_data, 18);
    tick();
    wait_rsp1(10);
    chk("t2_second_id", b1.rsp_id, 1);
    chk("t2_second_data", b1.rsp_data, 6);
    b1.r0_valid = 0; b1.r1_valid = 0;
    tick();

    // Continuous contention alternates grants
    do_reset();
    b1.r0_valid = 1; b1.r0_op = 3'd4; b1.r0_a = 3'd4; b1.r0_b = 3'd2;
    b1.r1_valid = 1; b1.r1_op = 3'd5; b1.r1_a = 3'd1; b1.r1_b = 3'd2;
    for (int i = 0; i < 6; i++) begin
      wait_rsp1(10);
      chk("t3_id", b1.rsp_id, i % 2);
      chk("t3_data", b1.rsp_data, (i % 2) ? 4 : 1);
      tick();
    end
    b1.r0_valid = 0; b1.r1_valid = 0;
    tick();

    // Response back-pressure holds result and blocks new accepts
    do_reset();
    b1.rsp_ready = 0;
    b1.r1_valid = 1; b1.r1_op = 3'd7; b1.r1_a = 3'd3; b1.r1_b = 3'd3;
    #1;
    chk("t4_r1_ready", b1.r1_ready, 1);
    tick();
    b1.r1_valid = 0;
    b1.r0_valid = 1; b1.r0_op = 3'd0; b1.r0_a = 3'd6; b1.r0_b = 3'd3;
    tick();
    chk("t4_rsp_valid", b1.rsp_valid, 1);
    chk("t4_rsp_data", b1.rsp_data, 1);
    chk("t4_rsp_id", b1.rsp_id, 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t4_hold_valid", b1.rsp_valid, 1);
      chk("t4_hold_data", b1.rsp_data, 1);
      chk("t4_hold_id", b1.rsp_id, 1);
      chk("t4_no_accept", b1.r0_ready, 0);
    end
    b1.rsp_ready = 1;
    #1;
    chk("t4_no_bypass", b1.r0_ready, 0);
    tick();
    chk("t4_rsp_done", b1.rsp_valid, 0);
    chk("t4_r0_ready_after", b1.r0_ready, 1);
    tick();
    b1.r0_valid = 0;
    chk("t4_r0_alu_a", b1.alu_a, 6);
    chk("t4_r0_busy", b1.busy, 1);
    wait_rsp1(10);
    chk("t4_r0_data", b1.rsp_data, 2);
    chk("t4_r0_id", b1.rsp_id, 0);
    tick();

    // SETTLE=3: operands held three cycles, XNOR result captured
    b3.rsp_ready = 1;
    b3.r0_valid = 1; b3.r0_op = 3'd6; b3.r0_a = 3'd7; b3.r0_b = 3'd5;
    #1;
    chk("t5_r0_ready", b3.r0_ready, 1);
    tick();
    b3.r0_valid = 0;
    for (int k = 0; k < 3; k++) begin
      chk("t5_busy", b3.busy, 1);
      chk("t5_alu_op", b3.alu_op, 6);
      chk("t5_alu_a", b3.alu_a, 7);
      chk("t5_alu_b", b3.alu_b, 5);
      chk("t5_not_yet", b3.rsp_valid, 0);
      tick();
    end
    chk("t5_rsp_valid", b3.rsp_valid, 1);
    chk("t5_rsp_data", b3.rsp_data, 5);
    chk("t5_rsp_id", b3.rsp_id, 0);
    tick();
    chk("t5_idle", b3.busy, 0);
    chk("t5_alu_hold", b3.alu_a, 7);

    // Reset during EXEC abandons the operation
    b1.r1_valid = 1; b1.r1_op = 3'd1; b1.r1_a = 3'd7; b1.r1_b = 3'd1;
    #1;
    chk("t6_r1_ready", b1.r1_ready, 1);
    tick();
    b1.r1_valid = 0;
    chk("t6_in_exec", b1.busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_busy", b1.busy, 0);
    chk("t6_rsp_valid", b1.rsp_valid, 0);
    chk("t6_rsp_data", b1.rsp_data, 0);
    chk("t6_alu_op", b1.alu_op, 0);
    chk("t6_alu_a", b1.alu_a, 0);
    chk("t6_alu_b", b1.alu_b, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t6_no_rsp", b1.rsp_valid, 0);
    end
    b1.r0_valid = 1; b1.r0_op = 3'd1; b1.r0_a = 3'd2; b1.r0_b = 3'd2;
    b1.r1_valid = 1;
    #1;
    chk("t6_tie_r0", b1.r0_ready, 1);
    chk("t6_tie_r1", b1.r1_ready, 0);
    b1.r0_valid = 0; b1.r1_valid = 0;
    tick();

    chk("ready_while_busy", viol, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
